// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory bus between the imem and dmem
// requesters, with SoC address decode and an error response for unmapped addresses.
module mem_arbiter #(
    parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
    parameter logic [31:0] ROM_TOP    = 32'h0000_0080,
    parameter logic [31:0] UART_BASE  = 32'h0100_0000,
    parameter logic [31:0] UART_TOP   = 32'h0100_0004,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_TOP  = 32'h0200_C000,
    parameter logic [31:0] TIM0_BASE  = 32'h1000_0000,
    parameter logic [31:0] TIM0_TOP   = 32'h1008_0000,
    parameter logic [31:0] TIM1_BASE  = 32'h2000_0000,
    parameter logic [31:0] TIM1_TOP   = 32'h2008_0000,
    parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
    parameter logic [31:0] RAM_TOP    = 32'h8010_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    output logic        imem_error,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_error,
    output logic        slv_valid,
    output logic        slv_instr,
    output logic [2:0]  slv_sel,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wstrb,
    input  logic [31:0] slv_rdata,
    input  logic        slv_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    localparam int NUM_REGIONS = 6;
    // Index order matches the slv_sel encoding.
    localparam logic [NUM_REGIONS-1:0][31:0] REGION_BASE =
        {RAM_BASE, TIM1_BASE, TIM0_BASE, CLINT_BASE, UART_BASE, ROM_BASE};
    localparam logic [NUM_REGIONS-1:0][31:0] REGION_TOP =
        {RAM_TOP, TIM1_TOP, TIM0_TOP, CLINT_TOP, UART_TOP, ROM_TOP};

    state_t state_reg, state_next;

    logic        pend_i_reg, pend_i_next;
    logic [31:0] pend_i_addr_reg, pend_i_addr_next;
    logic        pend_d_reg, pend_d_next;
    logic [31:0] pend_d_addr_reg, pend_d_addr_next;
    logic [31:0] pend_d_wdata_reg, pend_d_wdata_next;
    logic [3:0]  pend_d_wstrb_reg, pend_d_wstrb_next;
    logic        last_grant_d_reg, last_grant_d_next;
    logic        owner_i_reg, owner_i_next;

    logic        slv_valid_reg, slv_valid_next;
    logic        slv_instr_reg, slv_instr_next;
    logic [2:0]  slv_sel_reg, slv_sel_next;
    logic [31:0] slv_addr_reg, slv_addr_next;
    logic [31:0] slv_wdata_reg, slv_wdata_next;
    logic [3:0]  slv_wstrb_reg, slv_wstrb_next;
    logic        imem_ready_reg, imem_ready_next;
    logic        imem_error_reg, imem_error_next;
    logic [31:0] imem_rdata_reg, imem_rdata_next;
    logic        dmem_ready_reg, dmem_ready_next;
    logic        dmem_error_reg, dmem_error_next;
    logic [31:0] dmem_rdata_reg, dmem_rdata_next;

    logic                   req_i, req_d, grant_i, grant_d, grant_any;
    logic [31:0]            grant_addr, grant_wdata;
    logic [3:0]             grant_wstrb;
    logic [NUM_REGIONS-1:0] region_hit;
    logic                   grant_mapped;
    logic [2:0]             grant_sel;

    // Arbitration: a live valid or a parked request both count as a request.
    assign req_i     = imem_valid | pend_i_reg;
    assign req_d     = dmem_valid | pend_d_reg;
    assign grant_i   = (state_reg == IDLE) && req_i && (!req_d || last_grant_d_reg);
    assign grant_d   = (state_reg == IDLE) && req_d && !grant_i;
    assign grant_any = grant_i | grant_d;

    always_comb begin
        grant_addr  = '0;
        grant_wdata = '0;
        grant_wstrb = '0;
        if (grant_i) begin
            grant_addr = imem_valid ? imem_addr : pend_i_addr_reg;
        end else if (grant_d) begin
            grant_addr  = dmem_valid ? dmem_addr  : pend_d_addr_reg;
            grant_wdata = dmem_valid ? dmem_wdata : pend_d_wdata_reg;
            grant_wstrb = dmem_valid ? dmem_wstrb : pend_d_wstrb_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign region_hit[gi] = (grant_addr >= REGION_BASE[gi]) &&
                                    (grant_addr <  REGION_TOP[gi]);
        end
    endgenerate

    assign grant_mapped = |region_hit;

    // Regions are disjoint, so at most one hit bit is set.
    always_comb begin
        grant_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_hit[i]) begin
                grant_sel = 3'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant_any) state_next = grant_mapped ? BUSY : ERR;
            BUSY: if (slv_ready) state_next = IDLE;
            ERR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pend_i_next       = pend_i_reg;
        pend_i_addr_next  = pend_i_addr_reg;
        pend_d_next       = pend_d_reg;
        pend_d_addr_next  = pend_d_addr_reg;
        pend_d_wdata_next = pend_d_wdata_reg;
        pend_d_wstrb_next = pend_d_wstrb_reg;
        last_grant_d_next = last_grant_d_reg;
        owner_i_next      = owner_i_reg;
        slv_valid_next    = 1'b0;
        slv_instr_next    = slv_instr_reg;
        slv_sel_next      = slv_sel_reg;
        slv_addr_next     = slv_addr_reg;
        slv_wdata_next    = slv_wdata_reg;
        slv_wstrb_next    = slv_wstrb_reg;
        imem_ready_next   = 1'b0;
        imem_error_next   = 1'b0;
        imem_rdata_next   = imem_rdata_reg;
        dmem_ready_next   = 1'b0;
        dmem_error_next   = 1'b0;
        dmem_rdata_next   = dmem_rdata_reg;

        // A valid that loses arbitration is parked; a repeat while parked is dropped.
        if (grant_i) begin
            pend_i_next = 1'b0;
        end else if (imem_valid && !pend_i_reg) begin
            pend_i_next      = 1'b1;
            pend_i_addr_next = imem_addr;
        end
        if (grant_d) begin
            pend_d_next = 1'b0;
        end else if (dmem_valid && !pend_d_reg) begin
            pend_d_next       = 1'b1;
            pend_d_addr_next  = dmem_addr;
            pend_d_wdata_next = dmem_wdata;
            pend_d_wstrb_next = dmem_wstrb;
        end

        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    last_grant_d_next = grant_d;
                    owner_i_next      = grant_i;
                    if (grant_mapped) begin
                        slv_valid_next = 1'b1;
                        slv_instr_next = grant_i;
                        slv_sel_next   = grant_sel;
                        slv_addr_next  = grant_addr;
                        slv_wdata_next = grant_wdata;
                        slv_wstrb_next = grant_wstrb;
                    end
                end
            end
            BUSY: begin
                if (slv_ready) begin
                    if (owner_i_reg) begin
                        imem_ready_next = 1'b1;
                        imem_rdata_next = slv_rdata;
                    end else begin
                        dmem_ready_next = 1'b1;
                        dmem_rdata_next = slv_rdata;
                    end
                end
            end
            ERR: begin
                if (owner_i_reg) begin
                    imem_ready_next = 1'b1;
                    imem_error_next = 1'b1;
                    imem_rdata_next = '0;
                end else begin
                    dmem_ready_next = 1'b1;
                    dmem_error_next = 1'b1;
                    dmem_rdata_next = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            pend_i_reg       <= 1'b0;
            pend_i_addr_reg  <= '0;
            pend_d_reg       <= 1'b0;
            pend_d_addr_reg  <= '0;
            pend_d_wdata_reg <= '0;
            pend_d_wstrb_reg <= '0;
            last_grant_d_reg <= 1'b1;
            owner_i_reg      <= 1'b0;
            slv_valid_reg    <= 1'b0;
            slv_instr_reg    <= 1'b0;
            slv_sel_reg      <= '0;
            slv_addr_reg     <= '0;
            slv_wdata_reg    <= '0;
            slv_wstrb_reg    <= '0;
            imem_ready_reg   <= 1'b0;
            imem_error_reg   <= 1'b0;
            imem_rdata_reg   <= '0;
            dmem_ready_reg   <= 1'b0;
            dmem_error_reg   <= 1'b0;
            dmem_rdata_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            pend_i_reg       <= pend_i_next;
            pend_i_addr_reg  <= pend_i_addr_next;
            pend_d_reg       <= pend_d_next;
            pend_d_addr_reg  <= pend_d_addr_next;
            pend_d_wdata_reg <= pend_d_wdata_next;
            pend_d_wstrb_reg <= pend_d_wstrb_next;
            last_grant_d_reg <= last_grant_d_next;
            owner_i_reg      <= owner_i_next;
            slv_valid_reg    <= slv_valid_next;
            slv_instr_reg    <= slv_instr_next;
            slv_sel_reg      <= slv_sel_next;
            slv_addr_reg     <= slv_addr_next;
            slv_wdata_reg    <= slv_wdata_next;
            slv_wstrb_reg    <= slv_wstrb_next;
            imem_ready_reg   <= imem_ready_next;
            imem_error_reg   <= imem_error_next;
            imem_rdata_reg   <= imem_rdata_next;
            dmem_ready_reg   <= dmem_ready_next;
            dmem_error_reg   <= dmem_error_next;
            dmem_rdata_reg   <= dmem_rdata_next;
        end
    end

    assign slv_valid  = slv_valid_reg;
    assign slv_instr  = slv_instr_reg;
    assign slv_sel    = slv_sel_reg;
    assign slv_addr   = slv_addr_reg;
    assign slv_wdata  = slv_wdata_reg;
    assign slv_wstrb  = slv_wstrb_reg;
    assign imem_ready = imem_ready_reg;
    assign imem_error = imem_error_reg;
    assign imem_rdata = imem_rdata_reg;
    assign dmem_ready = dmem_ready_reg;
    assign dmem_error = dmem_error_reg;
    assign dmem_rdata = dmem_rdata_reg;

endmodule
